data_mem_responder: RTL and testbench

Target-side responder for the CPU data-memory interface. It takes the CPU's address, write-enable and store-data outputs and returns registered load data one cycle later, so the data presented in the MEM stage comes back in the WB stage. Behind one interface it holds a word-addressed RAM and a small MMIO register block: a cycle counter, a GPIO output, a halt/exit register for simulation, and a countdown timer with an expiry pulse.

---
 rtl/data_mem_responder.sv | 152 +++++++++++++++
 tb/tb_data_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory target for the CPU: word RAM plus an MMIO block (cycle counter,
// GPIO, halt/exit, countdown timer). Load data is registered, latency 1.
module data_mem_responder #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned MMIO_BIT = 31
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_rw,
   input  logic [31:0] mem_aout,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic [31:0] gpio_out,
   output logic        halt,
   output logic [31:0] halt_code,
   output logic        timer_irq,
   output logic        bus_err
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   // Address bits between the RAM index and the MMIO select bit must be zero for a RAM hit.
   localparam logic [31:0] RAM_HI_MASK =
      ((32'd1 << MMIO_BIT) - 32'd1) & ~((32'd1 << ADDR_W) - 32'd1);

   localparam logic [3:0] OFF_CYCLE = 4'd0;
   localparam logic [3:0] OFF_GPIO  = 4'd1;
   localparam logic [3:0] OFF_HALT  = 4'd2;
   localparam logic [3:0] OFF_TIMER = 4'd3;

   logic [31:0] ram_q [DEPTH];
   logic        ram_we;
   logic [ADDR_W-1:0] ram_idx;

   logic [31:0] mem_din_q,   mem_din_d;
   logic [31:0] gpio_q,      gpio_d;
   logic        halt_q,      halt_d;
   logic [31:0] halt_code_q, halt_code_d;
   logic [31:0] cycle_q,     cycle_d;
   logic [31:0] timer_q,     timer_d;
   logic        irq_q,       irq_d;
   logic        bus_err_q,   bus_err_d;

   logic        is_mmio;
   logic        is_ram;
   logic [3:0]  mmio_off;

   assign is_mmio  = mem_aout[MMIO_BIT];
   assign is_ram   = !is_mmio && ((mem_aout & RAM_HI_MASK) == 32'd0);
   assign mmio_off = mem_aout[3:0];
   assign ram_idx  = mem_aout[ADDR_W-1:0];

   // Decode, register updates and write-first load data.
   always_comb begin
      mem_din_d   = 32'd0;
      gpio_d      = gpio_q;
      halt_d      = halt_q;
      halt_code_d = halt_code_q;
      cycle_d     = cycle_q + 32'd1;
      timer_d     = (timer_q != 32'd0) ? (timer_q - 32'd1) : 32'd0;
      irq_d       = (timer_q == 32'd1);
      bus_err_d   = bus_err_q;
      ram_we      = 1'b0;

      if (is_ram) begin
         if (mem_rw) begin
            ram_we    = 1'b1;
            mem_din_d = mem_dout;
         end else begin
            mem_din_d = ram_q[ram_idx];
         end
      end else if (is_mmio) begin
         case (mmio_off)
            OFF_CYCLE: begin
               mem_din_d = mem_rw ? mem_dout : cycle_q;
            end
            OFF_GPIO: begin
               if (mem_rw) begin
                  gpio_d    = mem_dout;
                  mem_din_d = mem_dout;
               end else begin
                  mem_din_d = gpio_q;
               end
            end
            OFF_HALT: begin
               if (mem_rw) begin
                  mem_din_d = mem_dout;
                  // Only the first exit code is kept.
                  if (!halt_q) begin
                     halt_d      = 1'b1;
                     halt_code_d = mem_dout;
                  end
               end else begin
                  mem_din_d = halt_code_q;
               end
            end
            OFF_TIMER: begin
               if (mem_rw) begin
                  // A reload overrides any expiry happening on the same edge.
                  mem_din_d = mem_dout;
                  timer_d   = mem_dout;
                  irq_d     = 1'b0;
               end else begin
                  mem_din_d = timer_q;
               end
            end
            default: begin
               bus_err_d = 1'b1;
            end
         endcase
      end else begin
         bus_err_d = 1'b1;
      end
   end

   // RAM array has no reset.
   always_ff @(posedge clock) begin
      if (ram_we) begin
         ram_q[ram_idx] <= mem_dout;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_din_q   <= 32'd0;
         gpio_q      <= 32'd0;
         halt_q      <= 1'b0;
         halt_code_q <= 32'd0;
         cycle_q     <= 32'd0;
         timer_q     <= 32'd0;
         irq_q       <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         mem_din_q   <= mem_din_d;
         gpio_q      <= gpio_d;
         halt_q      <= halt_d;
         halt_code_q <= halt_code_d;
         cycle_q     <= cycle_d;
         timer_q     <= timer_d;
         irq_q       <= irq_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign mem_din   = mem_din_q;
   assign gpio_out  = gpio_q;
   assign halt      = halt_q;
   assign halt_code = halt_code_q;
   assign timer_irq = irq_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: expected load data is queued at drive
// time and compared one edge later; side-band outputs are checked in place.
module tb_data_mem_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_rw;
   logic [31:0] mem_aout;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;
   logic [31:0] gpio_out;
   logic        halt;
   logic [31:0] halt_code;
   logic        timer_irq;
   logic        bus_err;

   localparam logic [31:0] A_CYC  = 32'h8000_0000;
   localparam logic [31:0] A_GPIO = 32'h8000_0001;
   localparam logic [31:0] A_HALT = 32'h8000_0002;
   localparam logic [31:0] A_TMR  = 32'h8000_0003;

   typedef struct {
      logic [31:0] exp;
      bit          en;
      string       tag;
   } sb_t;

   sb_t sb_q[$];
   int  passed = 0;
   int  total  = 0;
   logic [31:0] c1, c2;

   data_mem_responder dut (
      .clock     (clock),
      .reset     (reset),
      .mem_rw    (mem_rw),
      .mem_aout  (mem_aout),
      .mem_dout  (mem_dout),
      .mem_din   (mem_din),
      .gpio_out  (gpio_out),
      .halt      (halt),
      .halt_code (halt_code),
      .timer_irq (timer_irq),
      .bus_err   (bus_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drive one access, let one edge sample it, then compare mem_din against the queued entry.
   task automatic access(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp, input bit en, input string tag);
      sb_t e;
      mem_rw   = rw;
      mem_aout = addr;
      mem_dout = data;
      e.exp = exp;
      e.en  = en;
      e.tag = tag;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      e = sb_q.pop_front();
      if (e.en) chk(mem_din, e.exp, e.tag);
      @(negedge clock);
   endtask

   initial begin
      reset    = 1'b1;
      mem_rw   = 1'b0;
      mem_aout = 32'd0;
      mem_dout = 32'd0;
      #1 reset = 1'b0;
      #1;
      chk(mem_din, 32'd0, "rst_mem_din");
      chk(gpio_out, 32'd0, "rst_gpio");
      chk(32'(halt), 32'd0, "rst_halt");
      chk(halt_code, 32'd0, "rst_halt_code");
      chk(32'(timer_irq), 32'd0, "rst_irq");
      chk(32'(bus_err), 32'd0, "rst_bus_err");
      repeat (2) @(negedge clock);
      reset = 1'b1;

      access(1'b0, A_CYC, 32'd0, 32'd0, 1'b1, "cycle_first");

      // RAM write-first, read-after-write, undisturbed by a neighbouring read
      access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, "ram_wr_first");
      access(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b1, "ram_raw");
      access(1'b0, 32'h0000_0011, 32'd0, 32'd0, 1'b0, "ram_unwritten");
      access(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b1, "ram_reread");
      access(1'b1, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1, "ram_wr0");

      // GPIO
      access(1'b1, A_GPIO, 32'h0000_00A5, 32'h0000_00A5, 1'b1, "gpio_wr");
      chk(gpio_out, 32'h0000_00A5, "gpio_out");
      access(1'b0, A_GPIO, 32'd0, 32'h0000_00A5, 1'b1, "gpio_rd");

      // CYCLE is read-only and writes do not flag an error
      access(1'b1, A_CYC, 32'h55, 32'h55, 1'b1, "cycle_wr_first");
      chk(32'(bus_err), 32'd0, "cycle_wr_no_err");

      access(1'b0, A_CYC, 32'd0, 32'd0, 1'b0, "cycle_c1");
      c1 = mem_din;
      for (int i = 0; i < 6; i++) access(1'b0, A_GPIO, 32'd0, 32'h0000_00A5, 1'b1, "idle_gpio");
      access(1'b0, A_CYC, 32'd0, 32'd0, 1'b0, "cycle_c2");
      c2 = mem_din;
      chk(c2 - c1, 32'd7, "cycle_delta");

      force dut.cycle_q = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_q;
      access(1'b0, A_CYC, 32'd0, 32'hFFFF_FFFE, 1'b1, "cycle_fffe");
      access(1'b0, A_CYC, 32'd0, 32'hFFFF_FFFF, 1'b1, "cycle_ffff");
      access(1'b0, A_CYC, 32'd0, 32'h0000_0000, 1'b1, "cycle_wrap");

      // HALT keeps the first code
      access(1'b1, A_HALT, 32'h1, 32'h1, 1'b1, "halt_wr1");
      access(1'b1, A_HALT, 32'h2, 32'h2, 1'b1, "halt_wr2");
      chk(32'(halt), 32'd1, "halt_set");
      chk(halt_code, 32'h1, "halt_code");
      access(1'b0, A_HALT, 32'd0, 32'h1, 1'b1, "halt_rd");

      // TIMER=3: pulse on the third edge after the write
      access(1'b1, A_TMR, 32'd3, 32'd3, 1'b1, "tmr_wr3");
      chk(32'(timer_irq), 32'd0, "tmr3_irq_k0");
      for (int k = 1; k <= 5; k++) begin
         access(1'b0, A_TMR, 32'd0, (k <= 3) ? 32'(4 - k) : 32'd0, 1'b1, "tmr3_rd");
         chk(32'(timer_irq), (k == 3) ? 32'd1 : 32'd0, "tmr3_irq");
      end

      // Reload on the expiry edge suppresses the pulse
      access(1'b1, A_TMR, 32'd3, 32'd3, 1'b1, "tmr_wr3b");
      access(1'b0, A_TMR, 32'd0, 32'd3, 1'b1, "tmr3b_rd1");
      access(1'b0, A_TMR, 32'd0, 32'd2, 1'b1, "tmr3b_rd2");
      access(1'b1, A_TMR, 32'd8, 32'd8, 1'b1, "tmr_wr8");
      chk(32'(timer_irq), 32'd0, "tmr_reload_no_irq");
      for (int k = 1; k <= 10; k++) begin
         access(1'b0, A_TMR, 32'd0, (k <= 9) ? 32'(9 - k) : 32'd0, 1'b1, "tmr8_rd");
         chk(32'(timer_irq), (k == 8) ? 32'd1 : 32'd0, "tmr8_irq");
      end

      // Unmapped accesses
      chk(32'(bus_err), 32'd0, "bus_err_clear");
      access(1'b0, 32'h0000_0400, 32'd0, 32'd0, 1'b1, "unmap_ram_rd");
      chk(32'(bus_err), 32'd1, "bus_err_set");
      access(1'b1, 32'h0000_0400, 32'hBAD0_BAD0, 32'd0, 1'b0, "unmap_ram_wr");
      access(1'b0, 32'h0000_0000, 32'd0, 32'h1234_5678, 1'b1, "ram0_intact");
      chk(32'(bus_err), 32'd1, "bus_err_sticky");
      access(1'b0, 32'h8000_0009, 32'd0, 32'd0, 1'b1, "unmap_mmio_rd");
      chk(32'(bus_err), 32'd1, "bus_err_mmio");

      // Asynchronous reset mid-run
      access(1'b1, A_TMR, 32'd5, 32'd5, 1'b1, "tmr_wr5");
      access(1'b1, A_GPIO, 32'h0000_00A5, 32'h0000_00A5, 1'b1, "gpio_wr2");
      #2 reset = 1'b0;
      #1;
      chk(mem_din, 32'd0, "arst_mem_din");
      chk(gpio_out, 32'd0, "arst_gpio");
      chk(32'(halt), 32'd0, "arst_halt");
      chk(halt_code, 32'd0, "arst_halt_code");
      chk(32'(timer_irq), 32'd0, "arst_irq");
      chk(32'(bus_err), 32'd0, "arst_bus_err");
      @(negedge clock);
      reset = 1'b1;
      access(1'b0, A_CYC, 32'd0, 32'd0, 1'b1, "arst_cycle");
      access(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b1, "arst_ram_keep");
      access(1'b0, A_TMR, 32'd0, 32'd0, 1'b1, "arst_timer");
      for (int k = 0; k < 6; k++) begin
         access(1'b0, A_GPIO, 32'd0, 32'd0, 1'b1, "arst_gpio_rd");
         chk(32'(timer_irq), 32'd0, "arst_no_irq");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
